// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter with one shift level per register stage, carry/zero flags,
// sideband tag and a single global stall enable driven by the output handshake.
module shifter_pipe #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [$clog2(WIDTH)-1:0] in_d,
    input  logic [2:0]               in_op,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_res,
    output logic                     out_carry,
    output logic                     out_zero,
    output logic [TAG_W-1:0]         out_tag
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_ROL = 3'b001;
    localparam logic [2:0] OP_SRL = 3'b010;
    localparam logic [2:0] OP_ROR = 3'b011;
    localparam logic [2:0] OP_SRA = 3'b100;

    generate
        if ((WIDTH & (WIDTH - 1)) != 0 || WIDTH < 8 || WIDTH > 64) begin : g_bad_width
            $error("shifter_pipe: WIDTH must be a power of two in 8..64");
        end
    endgenerate

    function automatic logic [WIDTH-1:0] f_level(input logic [WIDTH-1:0] a,
                                                 input logic [2:0] op, input int s);
        logic [WIDTH-1:0] r;
        case (op)
            OP_SLL:  r = a << s;
            OP_ROL:  r = (a << s) | (a >> (WIDTH - s));
            OP_SRL:  r = a >> s;
            OP_ROR:  r = (a >> s) | (a << (WIDTH - s));
            OP_SRA:  r = WIDTH'($signed(a) >>> s);
            default: r = a;
        endcase
        return r;
    endfunction

    logic                             w_en;
    logic [SHW-1:0]                   r_vld;
    logic [SHW-1:0][WIDTH-1:0]        r_data;
    logic [SHW-1:0][SHW-1:0]          r_d;
    logic [SHW-1:0][2:0]              r_op;
    logic [SHW-1:0][TAG_W-1:0]        r_tag;
    logic [SHW-1:0]                   r_carry;
    logic                             r_zero;

    logic [SHW-1:0]                   w_src_vld;
    logic [SHW-1:0][WIDTH-1:0]        w_src_data;
    logic [SHW-1:0][SHW-1:0]          w_src_d;
    logic [SHW-1:0][2:0]              w_src_op;
    logic [SHW-1:0][TAG_W-1:0]        w_src_tag;
    logic [SHW-1:0]                   w_src_carry;
    logic [SHW-1:0][WIDTH-1:0]        w_nxt_data;
    logic [SHW-1:0]                   w_lidx;
    logic [SHW-1:0]                   w_ridx;
    logic                             w_carry0;
    logic                             w_unused;

    assign w_en     = !r_vld[SHW-1] || out_ready;
    assign in_ready = w_en;

    // Left ops lose bit WIDTH-d, i.e. index -d mod WIDTH; right ops lose bit d-1.
    assign w_lidx = -in_d;
    assign w_ridx = in_d - SHW'(1);

    always_comb begin
        w_carry0 = 1'b0;
        if (in_d != '0) begin
            case (in_op)
                OP_SLL, OP_ROL:         w_carry0 = in_a[w_lidx];
                OP_SRL, OP_ROR, OP_SRA: w_carry0 = in_a[w_ridx];
                default:                w_carry0 = 1'b0;
            endcase
        end
    end

    always_comb begin
        w_src_vld      = {r_vld[SHW-2:0], in_valid};
        w_src_data[0]  = in_a;
        w_src_d[0]     = in_d;
        w_src_op[0]    = in_op;
        w_src_tag[0]   = in_tag;
        w_src_carry[0] = w_carry0;
        for (int k = 1; k < SHW; k++) begin
            w_src_data[k]  = r_data[k-1];
            w_src_d[k]     = r_d[k-1];
            w_src_op[k]    = r_op[k-1];
            w_src_tag[k]   = r_tag[k-1];
            w_src_carry[k] = r_carry[k-1];
        end
        for (int k = 0; k < SHW; k++) begin
            w_nxt_data[k] = w_src_d[k][k] ? f_level(w_src_data[k], w_src_op[k], 1 << k)
                                          : w_src_data[k];
        end
    end

    // Whole pipe advances or holds together; bubbles are kept, not squeezed out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld   <= '0;
            r_data  <= '0;
            r_d     <= '0;
            r_op    <= '0;
            r_tag   <= '0;
            r_carry <= '0;
            r_zero  <= 1'b0;
        end else if (w_en) begin
            r_vld   <= w_src_vld;
            r_data  <= w_nxt_data;
            r_d     <= w_src_d;
            r_op    <= w_src_op;
            r_tag   <= w_src_tag;
            r_carry <= w_src_carry;
            r_zero  <= (w_nxt_data[SHW-1] == '0);
        end
    end

    assign w_unused  = ^{r_d[SHW-1], r_op[SHW-1]};

    assign out_valid = r_vld[SHW-1];
    assign out_res   = r_data[SHW-1];
    assign out_carry = r_carry[SHW-1];
    assign out_zero  = r_zero;
    assign out_tag   = r_tag[SHW-1];
endmodule

// File: tb/tb_shifter_pipe.sv
// Bench for shifter_pipe: WIDTH=16 and WIDTH=32 instances driven from the same stimulus,
// each checked by its own scoreboard plus directed vectors and handshake corner cases.
module tb_shifter_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid, out_ready;
    logic [2:0]  op;
    logic [3:0]  tag;
    logic [15:0] a16;
    logic [3:0]  d16;
    logic [31:0] a32;
    logic [4:0]  d32;

    logic        rdy16, ov16, c16, z16;
    logic [15:0] res16;
    logic [3:0]  tag16;
    logic        rdy32, ov32, c32, z32;
    logic [31:0] res32;
    logic [3:0]  tag32;

    shifter_pipe #(.WIDTH(16), .TAG_W(4)) u16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy16),
        .in_a(a16), .in_d(d16), .in_op(op), .in_tag(tag),
        .out_valid(ov16), .out_ready(out_ready), .out_res(res16),
        .out_carry(c16), .out_zero(z16), .out_tag(tag16)
    );

    shifter_pipe #(.WIDTH(32), .TAG_W(4)) u32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy32),
        .in_a(a32), .in_d(d32), .in_op(op), .in_tag(tag),
        .out_valid(ov32), .out_ready(out_ready), .out_res(res32),
        .out_carry(c32), .out_zero(z32), .out_tag(tag32)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        logic        c;
        logic        z;
        logic [3:0]  tag;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [3:0]  d;
        logic [3:0]  tag;
        logic [15:0] res;
        logic        c;
        logic        z;
    } vec_t;

    exp_t        q16[$];
    exp_t        q32[$];
    logic [19:0] log16[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          n_out16 = 0;
    vec_t        vt[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Reference: whole-word shift/rotate of a w-bit operand, independent of stage structure.
    function automatic exp_t model(input int w, input logic [63:0] a, input int d,
                                   input logic [2:0] o, input logic [3:0] t);
        exp_t        e;
        logic [63:0] m, r;
        logic        c;
        m = (64'd1 << w) - 64'd1;
        a = a & m;
        r = a;
        c = 1'b0;
        if (d != 0) begin
            case (o)
                3'd0: begin r = (a << d) & m;                 c = a[w-d]; end
                3'd1: begin r = ((a << d) | (a >> (w-d))) & m; c = a[w-d]; end
                3'd2: begin r = a >> d;                        c = a[d-1]; end
                3'd3: begin r = ((a >> d) | (a << (w-d))) & m; c = a[d-1]; end
                3'd4: begin
                    r = a >> d;
                    if (a[w-1]) r = r | (m & ~(m >> d));
                    c = a[d-1];
                end
                default: ;
            endcase
        end
        e.res = r;
        e.c   = c;
        e.z   = (r == 64'd0);
        e.tag = t;
        return e;
    endfunction

    always @(negedge clk) begin : mon16
        exp_t e;
        if (rst_n) begin
            if (in_valid && rdy16) q16.push_back(model(16, 64'(a16), int'(d16), op, tag));
            if (ov16 && out_ready) begin
                n_out16++;
                log16.push_back({tag16, res16});
                if (q16.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL sb16_unexpected: got res %0h tag %0h, required no output", res16, tag16);
                end else begin
                    e = q16.pop_front();
                    chk("sb16_res", 64'(res16), e.res);
                    chk("sb16_carry", 64'(c16), 64'(e.c));
                    chk("sb16_zero", 64'(z16), 64'(e.z));
                    chk("sb16_tag", 64'(tag16), 64'(e.tag));
                end
            end
        end
    end

    always @(negedge clk) begin : mon32
        exp_t e;
        if (rst_n) begin
            if (in_valid && rdy32) q32.push_back(model(32, 64'(a32), int'(d32), op, tag));
            if (ov32 && out_ready) begin
                if (q32.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL sb32_unexpected: got res %0h tag %0h, required no output", res32, tag32);
                end else begin
                    e = q32.pop_front();
                    chk("sb32_res", 64'(res32), e.res);
                    chk("sb32_carry", 64'(c32), 64'(e.c));
                    chk("sb32_zero", 64'(z32), 64'(e.z));
                    chk("sb32_tag", 64'(tag32), 64'(e.tag));
                end
            end
        end
    end

    // Single op into an idle pipe; result must first be valid on the 4th cycle after acceptance.
    task automatic run_vec(input int i, input vec_t v);
        int cnt;
        @(posedge clk); #1;
        op = v.op; a16 = v.a; d16 = v.d; tag = v.tag;
        a32 = {v.a, v.a}; d32 = {1'b0, v.d};
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!ov16 && cnt < 20);
        chk($sformatf("vec%0d_latency", i), 64'(cnt), 64'd4);
        chk($sformatf("vec%0d_res", i), 64'(res16), 64'(v.res));
        chk($sformatf("vec%0d_carry", i), 64'(c16), 64'(v.c));
        chk($sformatf("vec%0d_zero", i), 64'(z16), 64'(v.z));
        chk($sformatf("vec%0d_tag", i), 64'(tag16), 64'(v.tag));
        repeat (3) @(posedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        in_valid = 1'b0; out_ready = 1'b1;
        op = 3'd0; tag = 4'd0; a16 = '0; d16 = '0; a32 = '0; d32 = '0;

        vt[0]  = '{3'd0, 16'h8001, 4'd1,  4'd3,  16'h0002, 1'b1, 1'b0};
        vt[1]  = '{3'd1, 16'hF001, 4'd4,  4'd1,  16'h001F, 1'b1, 1'b0};
        vt[2]  = '{3'd3, 16'h000F, 4'd4,  4'd2,  16'hF000, 1'b1, 1'b0};
        vt[3]  = '{3'd1, 16'h1234, 4'd0,  4'd4,  16'h1234, 1'b0, 1'b0};
        vt[4]  = '{3'd4, 16'h8000, 4'd15, 4'd5,  16'hFFFF, 1'b0, 1'b0};
        vt[5]  = '{3'd2, 16'h8000, 4'd15, 4'd6,  16'h0001, 1'b0, 1'b0};
        vt[6]  = '{3'd2, 16'h0001, 4'd1,  4'd7,  16'h0000, 1'b1, 1'b1};
        vt[7]  = '{3'd6, 16'hABCD, 4'd7,  4'd8,  16'hABCD, 1'b0, 1'b0};
        vt[8]  = '{3'd4, 16'h8F0F, 4'd4,  4'd9,  16'hF8F0, 1'b1, 1'b0};
        vt[9]  = '{3'd0, 16'hFFFF, 4'd15, 4'd10, 16'h8000, 1'b1, 1'b0};
        vt[10] = '{3'd3, 16'h1234, 4'd8,  4'd11, 16'h3412, 1'b0, 1'b0};
        vt[11] = '{3'd7, 16'h0000, 4'd3,  4'd12, 16'h0000, 1'b0, 1'b1};
        vt[12] = '{3'd1, 16'h8000, 4'd1,  4'd13, 16'h0001, 1'b1, 1'b0};

        // Reset state
        #12;
        chk("rst_out_valid", 64'(ov16), 64'd0);
        chk("rst_out_res", 64'(res16), 64'd0);
        chk("rst_out_carry", 64'(c16), 64'd0);
        chk("rst_out_zero", 64'(z16), 64'd0);
        chk("rst_out_tag", 64'(tag16), 64'd0);
        chk("rst_in_ready", 64'(rdy16), 64'd1);
        chk("rst_out_valid32", 64'(ov32), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 13; i++) run_vec(i, vt[i]);

        // Back-pressure: 8 back-to-back SLL ops, 3-cycle output stall on first result
        n_out16 = 0;
        log16.delete();
        fork
            begin
                @(posedge clk); #1;
                for (int i = 0; i < 8; i++) begin
                    int g;
                    op = 3'd0; a16 = 16'(i + 1); d16 = 4'd1; tag = 4'(i);
                    a32 = 32'(i + 1); d32 = 5'd1; in_valid = 1'b1;
                    g = 0;
                    do begin
                        @(negedge clk);
                        g++;
                    end while (!rdy16 && g < 50);
                    @(posedge clk); #1;
                end
                in_valid = 1'b0;
            end
            begin
                int g;
                g = 0;
                do begin
                    @(posedge clk); #2;
                    g++;
                end while (!ov16 && g < 50);
                out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_in_ready", 64'(rdy16), 64'd0);
                    chk("stall_out_valid", 64'(ov16), 64'd1);
                    chk("stall_res", 64'(res16), 64'h2);
                    chk("stall_tag", 64'(tag16), 64'd0);
                    chk("stall_carry", 64'(c16), 64'd0);
                    chk("stall_zero", 64'(z16), 64'd0);
                    @(posedge clk); #2;
                end
                out_ready = 1'b1;
            end
        join
        repeat (20) @(posedge clk);
        chk("bp_out_count", 64'(n_out16), 64'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < log16.size()) chk($sformatf("bp_out%0d", i), 64'(log16[i]), {44'd0, 4'(i), 16'(2 * (i + 1))});
        end

        // Reset mid-flight
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            op = 3'd1; a16 = 16'(16'h1111 * (i + 1)); d16 = 4'd3; tag = 4'(8 + i);
            a32 = 32'(a16); d32 = 5'd3; in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("mid_pre_valid", 64'(ov16), 64'd1);
        #2;
        rst_n = 1'b0;
        q16.delete();
        q32.delete();
        #1;
        chk("mid_rst_valid", 64'(ov16), 64'd0);
        chk("mid_rst_valid32", 64'(ov32), 64'd0);
        chk("mid_rst_ready", 64'(rdy16), 64'd1);
        chk("mid_rst_res", 64'(res16), 64'd0);
        chk("mid_rst_tag", 64'(tag16), 64'd0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("post_rst_valid", 64'(ov16), 64'd0);
            chk("post_rst_valid32", 64'(ov32), 64'd0);
            chk("post_rst_ready", 64'(rdy16), 64'd1);
        end

        // Random regression with random back-pressure
        for (int n = 0; n < 10000; n++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom_range(0, 1));
            op  = 3'($urandom_range(0, 7));
            tag = 4'($urandom_range(0, 15));
            a16 = 16'($urandom);
            a32 = $urandom;
            d16 = 4'($urandom_range(0, 15));
            d32 = 5'($urandom_range(0, 31));
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int g = 0; g < 100 && (q16.size() != 0 || q32.size() != 0); g++) @(negedge clk);
        chk("drain16", 64'(q16.size()), 64'd0);
        chk("drain32", 64'(q32.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
